muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the pipelined MIPS core, parametrised in datapath width `XLEN`. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the architectural HI/LO registers. It sits beside the EX stage. The pipeline issues an operation with `start`, stalls on `busy`, and reads `hi`/`lo` at any time. It also supports MTHI/MTLO writes and an abort on branch/jump flush.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// encoding and width-generic two's-complement helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  // Helpers work on a wide container; callers zero-extend in and truncate out,
  // which is exact for negation modulo 2^W.  Covers XLEN up to 64.
  localparam int MAXW = 128;

  function automatic logic [MAXW-1:0] twos_neg(input logic [MAXW-1:0] x);
    return ~x + {{(MAXW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [MAXW-1:0] cond_neg(input logic [MAXW-1:0] x, input logic en);
    return en ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers;
// one radix-2 step per RUN cycle, sign fix-up and commit in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wr_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   a_orig;
  logic              is_div, neg_res, neg_rem, div_zero;

  logic              accept, signed_op, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN:0]     rem_step;
  logic [XLEN-1:0]   quot, rem_out, res_hi, res_lo;

  assign busy   = (state != ST_IDLE);
  assign accept = (state == ST_IDLE) && start && !flush;

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = ST_RUN; else state_nxt = ST_IDLE;
        ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_FIX; else state_nxt = ST_RUN;
        ST_FIX:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= {CW{1'b0}};
    end else begin
      state <= state_nxt;
      if (state == ST_RUN && !flush) cnt <= cnt + CNT_ONE;
      else                           cnt <= {CW{1'b0}};
    end
  end

  // Operand magnitudes and one shift-add / restoring-divide step.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & a[XLEN-1];
    b_neg     = signed_op & b[XLEN-1];
    a_mag     = XLEN'(cond_neg(MAXW'(a), a_neg));
    b_mag     = XLEN'(cond_neg(MAXW'(b), b_neg));

    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_shift = {rem, acc[XLEN-1]};
    div_diff  = div_shift - {2'b00, opnd};
    div_ge    = ~div_diff[XLEN+1];
    if (is_div) begin
      rem_step = div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
      acc_step = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], div_ge};
    end else begin
      rem_step = rem;
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign correction and special-case selection for the FIX commit.
  always_comb begin
    prod    = (2*XLEN)'(cond_neg(MAXW'(acc), neg_res));
    quot    = XLEN'(cond_neg(MAXW'(acc[XLEN-1:0]), neg_res));
    rem_out = XLEN'(cond_neg(MAXW'(rem[XLEN-1:0]), neg_rem));
    if (!is_div) begin
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
    end else if (div_zero) begin
      res_hi = a_orig;
      res_lo = {XLEN{1'b1}};
    end else begin
      res_hi = rem_out;
      res_lo = quot;
    end
  end

  // Datapath registers, HI/LO and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= {(2*XLEN){1'b0}};
      rem      <= {(XLEN+1){1'b0}};
      opnd     <= {XLEN{1'b0}};
      a_orig   <= {XLEN{1'b0}};
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= {XLEN{1'b0}};
      lo       <= {XLEN{1'b0}};
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Multiply keeps the multiplicand in opnd; divide keeps the divisor.
        is_div   <= op[1];
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg & (op == OP_DIV);
        div_zero <= op[1] && (b == {XLEN{1'b0}});
        a_orig   <= a;
        opnd     <= op[1] ? b_mag : a_mag;
        acc      <= {{XLEN{1'b0}}, (op[1] ? a_mag : b_mag)};
        rem      <= {(XLEN+1){1'b0}};
      end else if (state == ST_RUN && !flush) begin
        acc <= acc_step;
        rem <= rem_step;
      end
      if (state == ST_FIX && !flush) begin
        hi   <= res_hi;
        lo   <= res_lo;
        done <= 1'b1;
      end else if (state == ST_IDLE && !accept) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases with literal results plus
// random traffic compared every cycle against a transaction-level model.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0, b = 32'd0, wr_data = 32'd0;
  logic        wr_hi = 1'b0, wr_lo = 1'b0, flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_left = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} straight from the arithmetic definition.
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    logic signed [31:0] sx, sy, sq, sr;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return sp;
      end
      2'b01: return {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = sx / sy;
        sr = sx % sy;
        return {sr, sq};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic model_step(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic wh, input logic wl, input logic [31:0] wd, input logic fl);
    m_done = 1'b0;
    if (!m_busy) begin
      if (s && !fl) begin
        m_busy = 1'b1;
        m_left = XLEN + 1;
        m_pend = ref_res(o, x, y);
      end else begin
        if (wh) m_hi = wd;
        if (wl) m_lo = wd;
      end
    end else if (fl) begin
      m_busy = 1'b0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        {m_hi, m_lo} = m_pend;
      end
    end
  endtask

  task automatic cycle(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic wh, input logic wl, input logic [31:0] wd, input logic fl);
    start = s; op = o; a = x; b = y; wr_hi = wh; wr_lo = wl; wr_data = wd; flush = fl;
    @(posedge clk);
    model_step(s, o, x, y, wh, wl, wd, fl);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // Issue one op, wait (bounded) for done, check latency, busy width and literals.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
    int n, bc;
    check({name, "_model"}, ref_res(o, x, y), {eh, el});
    cycle(1'b1, o, x, y, 1'b0, 1'b0, 32'd0, 1'b0);
    check({name, "_accept"}, 64'(busy), 64'd1);
    n = 0;
    bc = 1;
    for (int k = 0; k < 40; k++) begin
      idle();
      n++;
      if (busy) bc++;
      if (done) break;
    end
    check({name, "_latency"}, 64'(n), 64'(XLEN + 1));
    check({name, "_busy_cycles"}, 64'(bc), 64'(XLEN + 1));
    check({name, "_hi"}, 64'(hi), 64'(eh));
    check({name, "_lo"}, 64'(lo), 64'(el));
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #6;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    #5 rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div_zero", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu_b2b", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    // MTHI/MTLO in IDLE, separately and together.
    idle();
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0000_00AA, 1'b0);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_00BB, 1'b0);
    check("mthi", 64'(hi), 64'h0000_00AA);
    check("mtlo", 64'(lo), 64'h0000_00BB);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_0077, 1'b0);
    check("mt_both_hi", 64'(hi), 64'h0000_0077);
    check("mt_both_lo", 64'(lo), 64'h0000_0077);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0000_1234, 1'b0);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_5678, 1'b0);

    // Flush ten cycles into a MULTU: no commit, no done.
    cycle(1'b1, 2'b01, 32'd9, 32'd9, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (10) idle();
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("flush_busy", 64'(busy), 64'd0);
    repeat (40) idle();
    check("flush_hi", 64'(hi), 64'h0000_1234);
    check("flush_lo", 64'(lo), 64'h0000_5678);

    // start together with flush stays idle.
    cycle(1'b1, 2'b01, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, 1'b1);
    check("start_flush_busy", 64'(busy), 64'd0);

    // start together with MTLO: start wins, write dropped.
    cycle(1'b1, 2'b01, 32'd3, 32'd5, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    repeat (XLEN) idle();
    check("wr_in_run_done", 64'(done), 64'd1);
    check("wr_in_run_lo", 64'(lo), 64'd15);
    check("wr_in_run_hi", 64'(hi), 64'd0);

    // Asynchronous reset in the middle of RUN.
    cycle(1'b1, 2'b00, 32'hFFFF_0000, 32'h0001_2345, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (5) idle();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    m_busy = 1'b0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    #1 rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic s, fl, wh, wl;
      s  = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 49) == 0);
      wh = ($urandom_range(0, 7) == 0);
      wl = ($urandom_range(0, 7) == 0);
      if (s && fl) begin
        wh = 1'b0;
        wl = 1'b0;
      end
      cycle(s, 2'($urandom_range(0, 3)), pick_val(), pick_val(), wh, wl, 32'($urandom), fl);
    end
    repeat (40) idle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout reached t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
